// File: rtl/bird_pkg.sv
// Shared definitions for the bird game datapath: control-FSM state codes,
// draw-sequence phases, screen geometry and colours.
package bird_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BIRD_COLOUR = 3'b110;
  localparam logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000;

  // Encodings must match the control FSM that drives the state input.
  typedef enum logic [2:0] {
    ST_START   = 3'b001,
    ST_RAISING = 3'b010,
    ST_FALLING = 3'b011,
    ST_STOP    = 3'b100,
    ST_DRAW    = 3'b111
  } bird_state_e;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_ERASE = 2'd1,
    PH_PAINT = 2'd2
  } draw_phase_e;

endpackage

// File: rtl/sprite_box_scanner.sv
// Walks a SIZE x SIZE box one pixel per clock, row-major with the column in the
// index LSBs. A start on the done cycle chains a new box with no gap cycle.
module sprite_box_scanner
  import bird_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          x0,
  input  logic [6:0]          y0,
  input  logic [COLOUR_W-1:0] colour,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] pixel_colour,
  output logic                plot,
  output logic                done
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int IW = 2 * CW;
  localparam logic [IW-1:0] LAST = IW'(SIZE * SIZE - 1);

  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [IW-1:0] idx;
  logic [IW-1:0] nidx;
  logic [CW-1:0] ncol;
  logic [CW-1:0] nrow;

  assign done = plot && (idx == LAST);
  assign nidx = idx + IW'(1);
  assign ncol = nidx[CW-1:0];
  assign nrow = nidx[IW-1:CW];

  // Pixel outputs are registered and simply hold once the box completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_x       <= '0;
      base_y       <= '0;
      idx          <= '0;
      x            <= '0;
      y            <= '0;
      pixel_colour <= '0;
      plot         <= 1'b0;
    end else if (start) begin
      base_x       <= x0;
      base_y       <= y0;
      idx          <= '0;
      x            <= x0;
      y            <= y0;
      pixel_colour <= colour;
      plot         <= 1'b1;
    end else if (done) begin
      plot <= 1'b0;
    end else if (plot) begin
      idx <= nidx;
      x   <= base_x + 8'(ncol);
      y   <= base_y + 7'(nrow);
    end
  end

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: moves the sprite on frame ticks, reports flag/touched to the
// control FSM, and erases/repaints the sprite box through one box scanner.
module bird_datapath
  import bird_pkg::*;
#(
  parameter int BIRD_X    = 20,
  parameter int BIRD_SIZE = 4,
  parameter int Y_START   = 56,
  parameter int TOP_Y     = 2,
  parameter int FLOOR_Y   = 115,
  parameter int RISE_STEP = 2,
  parameter int FALL_STEP = 1,
  parameter int RISE_MAX  = 16,
  parameter int PIPE_W    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          state,
  input  logic                frame_tick,
  input  logic [7:0]          pipe_x,
  input  logic [6:0]          gap_top,
  input  logic [6:0]          gap_bot,
  output logic                flag,
  output logic                touched,
  output logic [6:0]          bird_y,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                busy
);

  localparam logic [8:0] TOP9   = 9'(TOP_Y);
  localparam logic [8:0] RISE9  = 9'(RISE_STEP);
  localparam logic [8:0] FALL9  = 9'(FALL_STEP);
  localparam logic [8:0] LOW9   = 9'(FLOOR_Y - BIRD_SIZE + 1);
  localparam logic [8:0] FLOOR9 = 9'(FLOOR_Y);
  localparam logic [8:0] SZ9    = 9'(BIRD_SIZE);
  localparam logic [8:0] BX9    = 9'(BIRD_X);
  localparam logic [8:0] PW9    = 9'(PIPE_W);
  localparam logic [7:0] RSTEP8 = 8'(RISE_STEP);
  localparam logic [7:0] RMAX8  = 8'(RISE_MAX);
  localparam logic [6:0] YST7   = 7'(Y_START);
  localparam logic [6:0] TOP7   = 7'(TOP_Y);

  logic [6:0]  bird_y_q;
  logic [7:0]  rise_cnt_q;
  logic        flag_q;
  logic        touched_q;
  logic        move_q;
  logic        pending_q;
  draw_phase_e phase_q;
  draw_phase_e phase_d;

  logic        engaged;
  logic        accept;
  logic        scan_start;
  logic [6:0]  scan_y0;
  logic [COLOUR_W-1:0] scan_colour;
  logic        scan_done;

  logic [8:0]  y9;
  logic [8:0]  ny9;
  logic [8:0]  bot9;
  logic [8:0]  px9;
  logic [6:0]  y_new;
  logic [7:0]  rise_new;
  logic        flag_new;
  logic        x_overlap;
  logic        hit_floor;
  logic        hit_pipe;

  // Tick handshake: frame_tick is a one-cycle valid; the datapath is ready
  // when no move is in flight and no box is being drawn (engaged=0). A tick
  // seen while engaged is parked in a one-deep pending slot and replayed the
  // first ready cycle; ticks beyond that are dropped.
  assign busy    = (phase_q != PH_IDLE);
  assign engaged = move_q | busy;
  assign accept  = !engaged && (frame_tick || pending_q);

  always_comb begin
    y9       = {2'b00, bird_y_q};
    y_new    = bird_y_q;
    rise_new = rise_cnt_q;
    flag_new = flag_q;
    case (state)
      ST_RAISING: begin
        y_new    = (y9 >= TOP9 + RISE9) ? 7'(y9 - RISE9) : TOP7;
        rise_new = (rise_cnt_q >= RMAX8) ? rise_cnt_q : rise_cnt_q + RSTEP8;
        if (rise_cnt_q >= RMAX8 || bird_y_q == TOP7) flag_new = 1'b1;
      end
      ST_FALLING: begin
        y_new    = (y9 + FALL9 >= LOW9) ? 7'(LOW9) : 7'(y9 + FALL9);
        rise_new = '0;
        flag_new = 1'b0;
      end
      default: ;
    endcase
  end

  // Collision uses the post-move row in 9-bit arithmetic so nothing wraps.
  always_comb begin
    ny9       = {2'b00, y_new};
    bot9      = ny9 + SZ9 - 9'd1;
    px9       = {1'b0, pipe_x};
    hit_floor = (bot9 >= FLOOR9);
    x_overlap = (px9 <= BX9 + SZ9 - 9'd1) && (px9 + PW9 - 9'd1 >= BX9);
    hit_pipe  = x_overlap && ((ny9 < {2'b00, gap_top}) || (bot9 > {2'b00, gap_bot}));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_q     <= 1'b0;
      pending_q  <= 1'b0;
      bird_y_q   <= YST7;
      rise_cnt_q <= '0;
      flag_q     <= 1'b0;
      touched_q  <= 1'b0;
    end else begin
      move_q <= accept;
      if (accept) pending_q <= 1'b0;
      else if (frame_tick && engaged) pending_q <= 1'b1;
      if (move_q) begin
        if (state == ST_START) begin
          bird_y_q   <= YST7;
          rise_cnt_q <= '0;
          flag_q     <= 1'b0;
          touched_q  <= 1'b0;
        end else begin
          bird_y_q   <= y_new;
          rise_cnt_q <= rise_new;
          flag_q     <= flag_new;
          touched_q  <= touched_q | hit_floor | hit_pipe;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= PH_IDLE;
    else       phase_q <= phase_d;
  end

  // The erase is launched during the move cycle, while bird_y_q still holds
  // the old row; the paint is chained on the erase's last pixel.
  always_comb begin
    phase_d     = phase_q;
    scan_start  = 1'b0;
    scan_y0     = bird_y_q;
    scan_colour = BG_COLOUR;
    case (phase_q)
      PH_IDLE: begin
        if (move_q) begin
          scan_start = 1'b1;
          phase_d    = PH_ERASE;
        end
      end
      PH_ERASE: begin
        if (scan_done) begin
          scan_start  = 1'b1;
          scan_colour = BIRD_COLOUR;
          phase_d     = PH_PAINT;
        end
      end
      PH_PAINT: begin
        if (scan_done) phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  sprite_box_scanner #(
    .SIZE(BIRD_SIZE)
  ) u_scanner (
    .clk          (clk),
    .reset        (reset),
    .start        (scan_start),
    .x0           (8'(BIRD_X)),
    .y0           (scan_y0),
    .colour       (scan_colour),
    .x            (vga_x),
    .y            (vga_y),
    .pixel_colour (vga_colour),
    .plot         (plot),
    .done         (scan_done)
  );

  assign bird_y  = bird_y_q;
  assign flag    = flag_q;
  assign touched = touched_q;

endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath: movement, flag, collisions, draw sequence,
// tick queuing and asynchronous reset.
module tb_bird_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state;
  logic       frame_tick;
  logic [7:0] pipe_x;
  logic [6:0] gap_top;
  logic [6:0] gap_bot;
  logic       flag;
  logic       touched;
  logic [6:0] bird_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  localparam logic [2:0] S_START = 3'b001;
  localparam logic [2:0] S_RAISE = 3'b010;
  localparam logic [2:0] S_FALL  = 3'b011;
  localparam logic [2:0] S_STOP  = 3'b100;

  bird_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .frame_tick (frame_tick),
    .pipe_x     (pipe_x),
    .gap_top    (gap_top),
    .gap_bot    (gap_bot),
    .flag       (flag),
    .touched    (touched),
    .bird_y     (bird_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_capture();
    if (plot) got_q.push_back({vga_x, vga_y, vga_colour});
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    bit seen = 1'b0;
    while (n < 200 && !(seen && !busy)) begin
      if (busy) seen = 1'b1;
      step_capture();
      n++;
    end
    check("draw_done", {30'd0, seen, busy}, 32'd2);
  endtask

  task automatic tick(input logic [2:0] st);
    state = st;
    got_q.delete();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle();
  endtask

  task automatic expect_box(input logic [6:0] y, input logic [2:0] col);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back({8'(20 + c), 7'(int'(y) + r), col});
  endtask

  task automatic check_pixels(input string tag);
    check("pixel_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; state = S_STOP; frame_tick = 1'b0;
    pipe_x = 8'd100; gap_top = 7'd30; gap_bot = 7'd60;
    repeat (3) @(negedge clk);
    check("rst_bird_y", bird_y, 56);
    check("rst_flag", flag, 0);
    check("rst_touched", touched, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_vga_x", vga_x, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("no_tick_plot", plot, 0);
    check("no_tick_busy", busy, 0);

    // One falling tick: erase at 56, paint at 57.
    tick(S_FALL);
    expect_box(7'd56, 3'b000);
    expect_box(7'd57, 3'b110);
    check_pixels("draw_px");
    check("draw_y", bird_y, 57);
    check("idle_plot", plot, 0);
    check("hold_vga_x", vga_x, 23);
    check("hold_vga_y", vga_y, 60);
    check("hold_colour", vga_colour, 3'b110);

    tick(S_START);
    check("start_y", bird_y, 56);

    for (int k = 1; k <= 8; k++) begin
      tick(S_RAISE);
      check("rise_y", bird_y, 32'(56 - 2 * k));
      check("rise_flag", flag, 0);
    end
    tick(S_RAISE);
    check("rise9_y", bird_y, 38);
    check("rise9_flag", flag, 1);
    tick(S_FALL);
    check("fall_clr_y", bird_y, 39);
    check("fall_clr_flag", flag, 0);

    // Pipe collisions with gap 30..60.
    tick(S_START);
    for (int k = 0; k < 6; k++) tick(S_FALL);
    check("pipe_far_y", bird_y, 62);
    check("pipe_far_t", touched, 0);
    pipe_x = 8'd24;
    tick(S_STOP);
    check("pipe24_t", touched, 0);
    pipe_x = 8'd23;
    tick(S_STOP);
    check("pipe23_t", touched, 1);
    tick(S_START);
    check("start_clr_t", touched, 0);
    pipe_x = 8'd100;
    for (int k = 0; k < 8; k++) tick(S_RAISE);
    check("pipe_y40", bird_y, 40);
    pipe_x = 8'd18;
    tick(S_STOP);
    check("pipe_in_gap_t", touched, 0);
    check("pipe_in_gap_y", bird_y, 40);
    pipe_x = 8'd18;
    pipe_x = 8'd18;
    state = S_STOP;
    tick(S_STOP);
    pipe_x = 8'd100;
    tick(S_START);
    pipe_x = 8'd18;
    for (int k = 0; k < 6; k++) tick(S_FALL);
    check("pipe_hit_y", bird_y, 62);
    check("pipe_hit_t", touched, 1);
    pipe_x = 8'd100;

    // Ticks while busy: one accepted, three during the scan -> one extra redraw.
    tick(S_START);
    check("burst_start_y", bird_y, 56);
    state = S_FALL;
    got_q.delete();
    frame_tick = 1'b1;
    step_capture();
    frame_tick = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (5) step_capture();
      frame_tick = 1'b1;
      step_capture();
      frame_tick = 1'b0;
    end
    repeat (110) step_capture();
    expect_box(7'd56, 3'b000);
    expect_box(7'd57, 3'b110);
    expect_box(7'd57, 3'b000);
    expect_box(7'd58, 3'b110);
    check_pixels("burst_px");
    check("burst_y", bird_y, 58);
    check("burst_busy", busy, 0);

    // Fall to the floor.
    for (int k = 0; k < 52; k++) tick(S_FALL);
    check("floor110_y", bird_y, 110);
    check("floor110_t", touched, 0);
    tick(S_FALL);
    check("floor111_y", bird_y, 111);
    check("floor111_t", touched, 0);
    tick(S_FALL);
    check("floor112_y", bird_y, 112);
    check("floor112_t", touched, 1);
    tick(S_FALL);
    check("clamp_y", bird_y, 112);
    check("clamp_t", touched, 1);

    // Asynchronous reset in the middle of a scan.
    state = S_FALL;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_scan_plot", plot, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_plot", plot, 0);
    check("arst_busy", busy, 0);
    check("arst_bird_y", bird_y, 56);
    check("arst_flag", flag, 0);
    check("arst_touched", touched, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Steady redraw: STOP tick holds y but still erases and repaints.
    tick(S_STOP);
    expect_box(7'd56, 3'b000);
    expect_box(7'd56, 3'b110);
    check_pixels("steady_px");
    check("steady_y", bird_y, 56);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
